// File: rtl/mem_skew_buf.sv
// mem_skew_buf: DIM x DIM signed operand tile buffer streaming rows or columns into
// DIM systolic lanes with optional diagonal skew, back-pressure and done/busy status.
// Ports: clk, rst (async, active-high); wr_en/wr_row/wr_data row write (IDLE only);
// clr tile zero (IDLE only, beats wr_en); start/transpose begin a stream;
// out_rdy consumer accept; out_data/out_vld registered lane step; busy in STREAM;
// done pulse after final accept; wr_err pulse on a write or clear dropped while busy.
module mem_skew_buf #(
    parameter int BITS = 8,
    parameter int DIM  = 8,
    parameter int SKEW = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [$clog2(DIM)-1:0]         wr_row,
    input  logic [DIM-1:0][BITS-1:0]       wr_data,
    input  logic                           clr,
    input  logic                           start,
    input  logic                           transpose,
    input  logic                           out_rdy,
    output logic [DIM-1:0][BITS-1:0]       out_data,
    output logic [DIM-1:0]                 out_vld,
    output logic                           busy,
    output logic                           done,
    output logic                           wr_err
);
    localparam int RW    = $clog2(DIM);
    localparam int TW    = $clog2(2 * DIM);
    localparam int NSTEP = (SKEW != 0) ? 2 * DIM - 1 : DIM;
    typedef enum logic {IDLE, STREAM} state_t;
    state_t                   state;
    logic                     mode, mode_n, go, adv, last;
    logic [TW-1:0]            t, tn;
    logic [BITS-1:0]          tile   [DIM][DIM];
    logic [BITS-1:0]          tile_n [DIM][DIM];
    logic [DIM-1:0][BITS-1:0] lane_d;
    logic [DIM-1:0]           lane_v;
    assign go     = (state == IDLE) && start;
    assign adv    = (state == STREAM) && out_rdy;
    assign last   = t == TW'(NSTEP - 1);
    assign mode_n = go ? transpose : mode;
    assign tn     = go ? '0 : t + 1'b1;
    // Next-edge tile contents; lanes are built from this so a write or clear
    // arriving with start is already visible in step 0.
    always_comb begin
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++)
                tile_n[r][c] = (state == IDLE && clr) ? '0 :
                               (state == IDLE && wr_en && wr_row == RW'(r)) ? wr_data[c] : tile[r][c];
    end
    // Lane i shows index k = tn - i (skewed) or tn (aligned); out-of-range lanes idle at zero.
    always_comb begin
        lane_d = '0;
        lane_v = '0;
        for (int i = 0; i < DIM; i++) begin
            automatic int k = int'(tn) - ((SKEW != 0) ? i : 0);
            if (k >= 0 && k < DIM) begin
                lane_v[i] = 1'b1;
                lane_d[i] = mode_n ? tile_n[k[RW-1:0]][i] : tile_n[i][k[RW-1:0]];
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            t        <= '0;
            mode     <= 1'b0;
            out_data <= '0;
            out_vld  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
            for (int r = 0; r < DIM; r++)
                for (int c = 0; c < DIM; c++)
                    tile[r][c] <= '0;
        end else begin
            tile   <= tile_n;
            done   <= adv && last;
            wr_err <= (state == STREAM) && (wr_en || clr);
            if (go || (adv && !last)) begin
                state    <= STREAM;
                busy     <= 1'b1;
                t        <= tn;
                mode     <= mode_n;
                out_data <= lane_d;
                out_vld  <= lane_v;
            end else if (adv) begin
                state    <= IDLE;
                busy     <= 1'b0;
                t        <= '0;
                out_data <= '0;
                out_vld  <= '0;
            end
        end
    end
endmodule
